apb2axi_issue_sched: RTL

- Scheduler between the request directory and the AXI read/write master front-ends.
- Each cycle it looks at which directory tags are PENDING (committed by the APB gateway but not yet issued) and picks one, round-robin.
- Outstanding AXI reads and writes are limited separately; a tag whose direction is at its limit is skipped.
- The picked tag goes out on a valid/ready issue channel. On the handshake the directory is told to move that entry to ISSUED.

---
 rtl/apb2axi_issue_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/apb2axi_issue_sched.sv
// rtl/apb2axi_issue_sched.sv - round-robin issue scheduler from directory PENDING tags to AXI front-ends
// Optional write priority: define APB2AXI_SCHED_WR_PRIO_EN.
module apb2axi_issue_sched #(
    parameter  int NUM_TAGS   = 16,
    parameter  int MAX_OUT_RD = 8,
    parameter  int MAX_OUT_WR = 8,
    localparam int TAG_W      = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                sched_en,
    input  logic [NUM_TAGS-1:0] pending_vec,
    input  logic [NUM_TAGS-1:0] is_write_vec,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [TAG_W-1:0]    issue_tag,
    output logic                issue_is_write,
    output logic                dir_issued_valid,
    input  logic                rd_done_valid,
    input  logic                wr_done_valid,
    output logic [7:0]          out_rd_cnt,
    output logic [7:0]          out_wr_cnt,
    output logic                cnt_err
);

    typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

    localparam logic [7:0] MAX_RD_C = 8'(MAX_OUT_RD);
    localparam logic [7:0] MAX_WR_C = 8'(MAX_OUT_WR);

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]   issue_tag_q, issue_tag_d;
    logic               issue_is_write_q, issue_is_write_d;
    logic [7:0]         out_rd_cnt_q, out_rd_cnt_d;
    logic [7:0]         out_wr_cnt_q, out_wr_cnt_d;
    logic               cnt_err_q, cnt_err_d;

    logic [NUM_TAGS-1:0] elig;
    logic [NUM_TAGS-1:0] cand;
    logic                rd_ok, wr_ok;
    logic                pick_found;
    logic [TAG_W-1:0]    pick_tag;
    logic [TAG_W-1:0]    scan_idx;
    int                  scan_sum;
    logic                hs, hs_rd, hs_wr;

    assign rd_ok = (out_rd_cnt_q < MAX_RD_C);
    assign wr_ok = (out_wr_cnt_q < MAX_WR_C);
    assign elig  = pending_vec & ((is_write_vec & {NUM_TAGS{wr_ok}}) |
                                  (~is_write_vec & {NUM_TAGS{rd_ok}}));

`ifdef APB2AXI_SCHED_WR_PRIO_EN
    assign cand = (|(elig & is_write_vec)) ? (elig & is_write_vec) : (elig & ~is_write_vec);
`else
    assign cand = elig;
`endif

    // First candidate at or after rr_ptr, wrapping modulo NUM_TAGS.
    always_comb begin
        pick_found = 1'b0;
        pick_tag   = '0;
        scan_sum   = 0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            scan_sum = int'(rr_ptr_q) + i;
            if (scan_sum >= NUM_TAGS) begin
                scan_sum = scan_sum - NUM_TAGS;
            end
            scan_idx = TAG_W'(scan_sum);
            if (!pick_found && cand[scan_idx]) begin
                pick_found = 1'b1;
                pick_tag   = scan_idx;
            end
        end
    end

    assign hs    = (state_q == S_ISSUE) & issue_ready;
    assign hs_rd = hs & ~issue_is_write_q;
    assign hs_wr = hs & issue_is_write_q;

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        issue_tag_d      = issue_tag_q;
        issue_is_write_d = issue_is_write_q;
        case (state_q)
            S_IDLE: begin
                if (sched_en && pick_found) begin
                    state_d          = S_ISSUE;
                    issue_tag_d      = pick_tag;
                    issue_is_write_d = is_write_vec[pick_tag];
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (issue_tag_q == TAG_W'(NUM_TAGS - 1)) ? '0 : issue_tag_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A done in the same cycle as a handshake cancels it; underflow saturates at 0.
    always_comb begin
        out_rd_cnt_d = out_rd_cnt_q;
        out_wr_cnt_d = out_wr_cnt_q;
        cnt_err_d    = cnt_err_q;
        if (hs_rd && !rd_done_valid) begin
            out_rd_cnt_d = out_rd_cnt_q + 8'd1;
        end else if (!hs_rd && rd_done_valid) begin
            if (out_rd_cnt_q != 8'd0) out_rd_cnt_d = out_rd_cnt_q - 8'd1;
            else                      cnt_err_d    = 1'b1;
        end
        if (hs_wr && !wr_done_valid) begin
            out_wr_cnt_d = out_wr_cnt_q + 8'd1;
        end else if (!hs_wr && wr_done_valid) begin
            if (out_wr_cnt_q != 8'd0) out_wr_cnt_d = out_wr_cnt_q - 8'd1;
            else                      cnt_err_d    = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q          <= S_IDLE;
            rr_ptr_q         <= '0;
            issue_tag_q      <= '0;
            issue_is_write_q <= 1'b0;
            out_rd_cnt_q     <= 8'd0;
            out_wr_cnt_q     <= 8'd0;
            cnt_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            issue_tag_q      <= issue_tag_d;
            issue_is_write_q <= issue_is_write_d;
            out_rd_cnt_q     <= out_rd_cnt_d;
            out_wr_cnt_q     <= out_wr_cnt_d;
            cnt_err_q        <= cnt_err_d;
        end
    end

    assign issue_valid      = (state_q == S_ISSUE);
    assign issue_tag        = issue_tag_q;
    assign issue_is_write   = issue_is_write_q;
    assign dir_issued_valid = hs;
    assign out_rd_cnt       = out_rd_cnt_q;
    assign out_wr_cnt       = out_wr_cnt_q;
    assign cnt_err          = cnt_err_q;

endmodule
